multicycle_control: RTL and testbench

- Multicycle successor to the single-cycle ARM-subset control unit; replaces it in the multicycle datapath.
- An FSM sequences fetch, decode, execute, memory and writeback over several cycles.
- Includes the ALU decode, an NZCV flag register and condition logic.
- Generalised ALU-control width, a memory ready handshake, and condition-fail early exit.

---
 rtl/multicycle_ctrl_pkg.sv | 76 +++++++
 rtl/multicycle_control_cond_check.sv | 38 +++
 rtl/multicycle_control.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit:
// FSM states, ALU/cond codes, mux encodings, op classes and the ALU decoder.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC,
        COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT,
        COND_GT, COND_LE, COND_AL, COND_NV
    } cond_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_EOR = 4'b0001;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    typedef struct packed {
        logic [2:0] op;
        logic       supported;
        logic       no_write;
        logic       cv_arith;
    } alu_dec_t;

    // cv_arith marks the ops whose carry/overflow are meaningful (ADD/SUB/CMP).
    function automatic alu_dec_t alu_decode(input logic [3:0] cmd, input logic eor_en);
        alu_dec_t d;
        d = '{op: ALU_ADD, supported: 1'b1, no_write: 1'b0, cv_arith: 1'b0};
        case (cmd)
            CMD_ADD: begin d.op = ALU_ADD; d.cv_arith = 1'b1; end
            CMD_SUB: begin d.op = ALU_SUB; d.cv_arith = 1'b1; end
            CMD_AND: d.op = ALU_AND;
            CMD_ORR: d.op = ALU_ORR;
            CMD_CMP: begin d.op = ALU_SUB; d.no_write = 1'b1; d.cv_arith = 1'b1; end
            CMD_EOR: begin
                if (eor_en) d.op = ALU_EOR;
                else        d.supported = 1'b0;
            end
            default: d.supported = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_control_cond_check.sv
// Combinational ARM condition evaluation: cond field + NZCV flags -> cond_ex.
// Kept standalone so a pipelined control unit can reuse it unchanged.
module cond_check
    import multicycle_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ex
);

    logic w_n, w_z, w_c, w_v, w_ge;

    assign {w_n, w_z, w_c, w_v} = i_flags;
    assign w_ge = (w_n == w_v);

    always_comb begin
        o_cond_ex = 1'b0;
        case (cond_t'(i_cond))
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = !w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = !w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = !w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = !w_v;
            COND_HI: o_cond_ex = w_c && !w_z;
            COND_LS: o_cond_ex = !w_c || w_z;
            COND_GE: o_cond_ex = w_ge;
            COND_LT: o_cond_ex = !w_ge;
            COND_GT: o_cond_ex = !w_z && w_ge;
            COND_LE: o_cond_ex = w_z || !w_ge;
            COND_AL: o_cond_ex = 1'b1;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle ARM-subset control unit: FSM, ALU decode, NZCV register, condition check.
// Optional retired-instruction counter enabled by defining MULTICYCLE_CTRL_PERF_EN.
module multicycle_control
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 2,
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            op,
    input  logic [3:0]            cond,
    input  logic [5:0]            funct,
    input  logic [3:0]            rd,
    input  logic [3:0]            alu_flag,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic                  mem_write,
    output logic [1:0]            result_src,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            imm_src,
    output logic [1:0]            reg_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [3:0]            flags,
    output logic [PERF_CNT_W-1:0] instr_retired
);

    localparam logic EOR_EN = (ALU_CTRL_W >= 3);

    state_t   r_state, w_next;
    logic     r_active;
    logic [3:0] r_flags;
    logic     w_cond_ex;
    logic     w_dp_state;
    logic     w_dp_write;
    logic     w_rd_pc;
    logic     w_flag_we;
    logic [2:0] w_alu_op;
    alu_dec_t w_dec;

    cond_check u_cond_check (
        .i_cond    (cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    assign w_dec      = alu_decode(funct[4:1], EOR_EN);
    assign w_dp_write = w_dec.supported && !w_dec.no_write;
    assign w_rd_pc    = (rd == 4'd15);
    assign w_alu_op   = w_dp_state ? w_dec.op : ALU_ADD;
    assign alu_control = ALU_CTRL_W'(w_alu_op);

    assign imm_src = op;
    assign reg_src = {op == OP_MEM, op == OP_BR};
    assign flags   = r_flags;

    // r_active stays low through reset and rises on the first edge after release,
    // so every strobe is zero until the first FETCH cycle actually begins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_active <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            r_state  <= w_next;
            r_active <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first; a path that skips an assignment would infer a latch.
        w_next     = r_state;
        w_dp_state = 1'b0;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        if (r_active) begin
            case (r_state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        w_next   = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    if (!w_cond_ex) begin
                        w_next = S_FETCH;
                    end else begin
                        case (op)
                            OP_DP:   w_next = funct[5] ? S_EXECUTEI : S_EXECUTER;
                            OP_MEM:  w_next = S_MEMADR;
                            OP_BR:   w_next = S_BRANCH;
                            default: w_next = S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: begin
                    alu_src_b = SRCB_IMM;
                    w_next    = funct[0] ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) w_next = S_MEMWB;
                end
                S_MEMWB: begin
                    result_src = RES_RDATA;
                    reg_write  = 1'b1;
                    pc_write   = w_rd_pc;
                    w_next     = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    adr_src   = 1'b1;
                    mem_write = mem_ready;
                    if (mem_ready) w_next = S_FETCH;
                end
                S_EXECUTER: begin
                    w_dp_state = 1'b1;
                    w_next     = S_ALUWB;
                end
                S_EXECUTEI: begin
                    w_dp_state = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    w_next     = S_ALUWB;
                end
                S_ALUWB: begin
                    w_dp_state = 1'b1;
                    result_src = RES_ALUOUT;
                    reg_write  = w_dp_write;
                    pc_write   = w_dp_write && w_rd_pc;
                    w_next     = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_b  = SRCB_IMM;
                    result_src = RES_ALU;
                    pc_write   = 1'b1;
                    w_next     = S_FETCH;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

    assign w_flag_we = r_active && w_cond_ex && funct[0] &&
                       ((r_state == S_EXECUTER) || (r_state == S_EXECUTEI));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else if (w_flag_we) begin
            if (w_dec.supported) r_flags[3:2] <= alu_flag[3:2];
            if (w_dec.cv_arith)  r_flags[1:0] <= alu_flag[1:0];
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [PERF_CNT_W-1:0] r_retired;

    // Any return to FETCH ends an instruction, including cond-fail and undefined ops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired <= '0;
        end else if ((r_state != S_FETCH) && (w_next == S_FETCH)) begin
            r_retired <= r_retired + PERF_CNT_W'(1);
        end
    end

    assign instr_retired = r_retired;
`else
    assign instr_retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-cycle strobe model is queued per
// instruction and compared each cycle against a 2-bit and a 3-bit ALU-control instance.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [3:0] cond;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flag;
    logic       mem_ready;

    logic d2_mem_req, d2_adr_src, d2_ir_write, d2_pc_write, d2_reg_write, d2_mem_write, d2_alu_src_a;
    logic [1:0] d2_result_src, d2_alu_src_b, d2_imm_src, d2_reg_src, d2_alu_control;
    logic [3:0] d2_flags;
    logic [31:0] d2_instr_retired;

    logic d3_mem_req, d3_adr_src, d3_ir_write, d3_pc_write, d3_reg_write, d3_mem_write, d3_alu_src_a;
    logic [1:0] d3_result_src, d3_alu_src_b, d3_imm_src, d3_reg_src;
    logic [2:0] d3_alu_control;
    logic [3:0] d3_flags;
    logic [31:0] d3_instr_retired;

    multicycle_control #(.ALU_CTRL_W(2), .PERF_CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .cond(cond), .funct(funct), .rd(rd),
        .alu_flag(alu_flag), .mem_ready(mem_ready),
        .mem_req(d2_mem_req), .adr_src(d2_adr_src), .ir_write(d2_ir_write),
        .pc_write(d2_pc_write), .reg_write(d2_reg_write), .mem_write(d2_mem_write),
        .result_src(d2_result_src), .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b),
        .imm_src(d2_imm_src), .reg_src(d2_reg_src), .alu_control(d2_alu_control),
        .flags(d2_flags), .instr_retired(d2_instr_retired)
    );

    multicycle_control #(.ALU_CTRL_W(3), .PERF_CNT_W(32)) dut3 (
        .clk(clk), .reset(reset), .op(op), .cond(cond), .funct(funct), .rd(rd),
        .alu_flag(alu_flag), .mem_ready(mem_ready),
        .mem_req(d3_mem_req), .adr_src(d3_adr_src), .ir_write(d3_ir_write),
        .pc_write(d3_pc_write), .reg_write(d3_reg_write), .mem_write(d3_mem_write),
        .result_src(d3_result_src), .alu_src_a(d3_alu_src_a), .alu_src_b(d3_alu_src_b),
        .imm_src(d3_imm_src), .reg_src(d3_reg_src), .alu_control(d3_alu_control),
        .flags(d3_flags), .instr_retired(d3_instr_retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, adr_src, ir_write, pc_write, reg_write, mem_write;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic [2:0] alu_ctl;
    } strb_t;

    typedef struct {
        logic       rdy;
        strb_t      s2;
        strb_t      s3;
        logic [3:0] flags;
    } exp_t;

    strb_t a2, a3;
    exp_t  sb[$];
    logic [3:0] m_flags;
    int    m_retired;
    int    total = 0;
    int    bad = 0;
    int    n_instr = 0;

    always_comb a2 = {d2_mem_req, d2_adr_src, d2_ir_write, d2_pc_write, d2_reg_write, d2_mem_write,
                      d2_result_src, d2_alu_src_a, d2_alu_src_b, d2_imm_src, d2_reg_src,
                      1'b0, d2_alu_control};
    always_comb a3 = {d3_mem_req, d3_adr_src, d3_ir_write, d3_pc_write, d3_reg_write, d3_mem_write,
                      d3_result_src, d3_alu_src_a, d3_alu_src_b, d3_imm_src, d3_reg_src,
                      d3_alu_control};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ARM pairs: even code tests a predicate, the odd code its complement.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v, base;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cc;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cc & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111)      cond_ok = 1'b0;
        else if (c == 4'b1110) cond_ok = 1'b1;
        else                   cond_ok = base ^ c[0];
    endfunction

    task automatic dec(input logic [5:0] f, input bit w3, output logic [2:0] ctl,
                       output bit wr, output bit nz, output bit cv);
        bit sup, arith;
        sup = 1; arith = 0; wr = 1; ctl = 3'd0;
        case (f[4:1])
            4'b0100: begin ctl = 3'd0; arith = 1; end
            4'b0010: begin ctl = 3'd1; arith = 1; end
            4'b0000: ctl = 3'd2;
            4'b1100: ctl = 3'd3;
            4'b1010: begin ctl = 3'd1; arith = 1; wr = 0; end
            4'b0001: if (w3) ctl = 3'd4; else sup = 0;
            default: sup = 0;
        endcase
        if (!sup) begin wr = 0; ctl = 3'd0; end
        nz = f[0] & sup;
        cv = f[0] & arith;
    endtask

    task automatic push(input strb_t s2, input strb_t s3, input logic rdy);
        exp_t e;
        e.rdy = rdy; e.s2 = s2; e.s3 = s3; e.flags = m_flags;
        sb.push_back(e);
    endtask

    // Queue the expected per-cycle strobes for one instruction; nf/nm are wait cycles.
    task automatic model_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                               input logic [3:0] r, input logic [3:0] af, input int nf, input int nm);
        strb_t b, s, s3;
        logic [2:0] c2, c3;
        bit w2, w3, nz, cv, nz3, cv3;
        op = o; cond = c; funct = f; rd = r; alu_flag = af;
        b = '0; b.imm_src = o; b.reg_src = {o == 2'b01, o == 2'b10};
        s = b; s.mem_req = 1; s.alu_src_a = 1; s.alu_src_b = 2'b10; s.result_src = 2'b10;
        repeat (nf) push(s, s, 1'b0);
        s.ir_write = 1; s.pc_write = 1;
        push(s, s, 1'b1);
        s = b; s.alu_src_a = 1; s.alu_src_b = 2'b10; s.result_src = 2'b10;
        push(s, s, 1'b1);
        m_retired++;
        if (!cond_ok(c, m_flags)) return;
        case (o)
            2'b01: begin
                s = b; s.alu_src_b = 2'b01;
                push(s, s, 1'b1);
                s = b; s.mem_req = 1; s.adr_src = 1;
                repeat (nm) push(s, s, 1'b0);
                if (f[0]) begin
                    push(s, s, 1'b1);
                    s = b; s.result_src = 2'b01; s.reg_write = 1; s.pc_write = (r == 4'd15);
                    push(s, s, 1'b1);
                end else begin
                    s.mem_write = 1;
                    push(s, s, 1'b1);
                end
            end
            2'b00: begin
                dec(f, 1'b0, c2, w2, nz, cv);
                dec(f, 1'b1, c3, w3, nz3, cv3);
                s = b; s.alu_src_b = f[5] ? 2'b01 : 2'b00; s.alu_ctl = c2;
                s3 = s; s3.alu_ctl = c3;
                push(s, s3, 1'b1);
                if (nz) m_flags[3:2] = af[3:2];
                if (cv) m_flags[1:0] = af[1:0];
                s = b;  s.alu_ctl = c2;  s.reg_write = w2;  s.pc_write = w2 && (r == 4'd15);
                s3 = b; s3.alu_ctl = c3; s3.reg_write = w3; s3.pc_write = w3 && (r == 4'd15);
                push(s, s3, 1'b1);
            end
            2'b10: begin
                s = b; s.alu_src_b = 2'b01; s.result_src = 2'b10; s.pc_write = 1;
                push(s, s, 1'b1);
            end
            default: ;
        endcase
    endtask

    // Entered at posedge+1; samples at the negedge, returns at the next posedge+1.
    task automatic drain(input int max_cyc);
        exp_t e;
        int cyc;
        cyc = 0;
        while (sb.size() > 0 && cyc < max_cyc) begin
            e = sb.pop_front();
            mem_ready = e.rdy;
            @(negedge clk);
            check($sformatf("i%0d.c%0d.strb2", n_instr, cyc), {14'd0, a2}, {14'd0, e.s2});
            check($sformatf("i%0d.c%0d.strb3", n_instr, cyc), {14'd0, a3}, {14'd0, e.s3});
            check($sformatf("i%0d.c%0d.flags", n_instr, cyc), {24'd0, d3_flags, d2_flags},
                  {24'd0, e.flags, e.flags});
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_retired();
        logic [31:0] exp_ret;
`ifdef MULTICYCLE_CTRL_PERF_EN
        exp_ret = 32'(m_retired);
`else
        exp_ret = 32'd0;
`endif
        check($sformatf("i%0d.retired2", n_instr), d2_instr_retired, exp_ret);
        check($sformatf("i%0d.retired3", n_instr), d3_instr_retired, exp_ret);
    endtask

    task automatic run(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic [3:0] af, input int nf, input int nm);
        model_instr(c, o, f, r, af, nf, nm);
        drain(1000);
        check_retired();
        n_instr++;
    endtask

    initial begin
        strb_t idle;
        reset = 1'b0; op = 2'b00; cond = 4'b1110; funct = '0; rd = '0;
        alu_flag = '0; mem_ready = 1'b1;
        m_flags = '0; m_retired = 0;
        repeat (2) @(negedge clk);
        check("reset.strb2", {14'd0, a2}, 32'd0);
        check("reset.flags", {28'd0, d2_flags}, 32'd0);
        check("reset.retired", d2_instr_retired, 32'd0);
        reset = 1'b1;
        #1;
        check("release.strb2", {14'd0, a2}, 32'd0);
        @(posedge clk);
        #1;

        run(4'b1110, 2'b00, 6'b001000, 4'd1, 4'b1010, 0, 0); // ADD R1: flags stay 0000
        run(4'b1110, 2'b00, 6'b000101, 4'd2, 4'b0110, 0, 0); // SUBS -> 0110
        run(4'b0000, 2'b00, 6'b001000, 4'd3, 4'b0000, 0, 0); // ADDEQ executes
        run(4'b0001, 2'b00, 6'b001000, 4'd3, 4'b0000, 0, 0); // ADDNE cond-fail
        run(4'b1110, 2'b01, 6'b011001, 4'd4, 4'b0000, 0, 3); // LDR, 3 wait cycles
        run(4'b1110, 2'b01, 6'b011000, 4'd4, 4'b0000, 2, 2); // STR, waits in FETCH and MEMWR
        run(4'b1110, 2'b00, 6'b000010, 4'd5, 4'b1111, 0, 0); // EOR: only 3-bit instance writes
        run(4'b1110, 2'b10, 6'b101000, 4'd0, 4'b0000, 1, 0); // B
        run(4'b1110, 2'b00, 6'b010101, 4'd6, 4'b1001, 0, 0); // CMP -> 1001, no write
        run(4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000, 0, 0); // LDR PC
        run(4'b1110, 2'b00, 6'b111000, 4'd15, 4'b0000, 0, 0); // ORR imm to PC
        run(4'b1110, 2'b11, 6'b000000, 4'd7, 4'b0000, 0, 0); // undefined op -> NOP
        run(4'b1110, 2'b00, 6'b001111, 4'd8, 4'b1111, 0, 0); // unsupported cmd: no writes
        run(4'b1110, 2'b00, 6'b000001, 4'd8, 4'b0101, 0, 0); // ANDS: NZ only
        run(4'b1100, 2'b00, 6'b001000, 4'd9, 4'b0000, 0, 0); // GT fails
        run(4'b1111, 2'b00, 6'b001000, 4'd9, 4'b0000, 0, 0); // NV never executes
        run(4'b1011, 2'b00, 6'b001000, 4'd9, 4'b0000, 0, 0); // LT passes

        // Reset in the middle of a stalled store, with all flags set.
        run(4'b1110, 2'b00, 6'b000101, 4'd2, 4'b1111, 0, 0);
        model_instr(4'b1110, 2'b01, 6'b011000, 4'd4, 4'b0000, 0, 3);
        drain(4);
        sb.delete();
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        idle = '0; idle.imm_src = 2'b01; idle.reg_src = 2'b10;
        check("midrst.strb2", {14'd0, a2}, {14'd0, idle});
        check("midrst.flags", {28'd0, d2_flags}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst.hold", {14'd0, a2}, {14'd0, idle});
        m_flags = '0; m_retired = 0;
        check_retired();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run(4'b1110, 2'b00, 6'b001000, 4'd1, 4'b0000, 0, 0);

        for (int i = 0; i < 8; i++) begin
            run(4'b1110, 2'b00, 6'b000101, 4'd2, 4'($urandom_range(0, 15)), 0, 0);
            run(4'($urandom_range(0, 15)), 2'b00, 6'b001000, 4'd3, 4'b0000, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
